// File: rtl/deser_align.sv
// ============================================================================
// Module      : deser_align
// Description : Serial-to-parallel receiver with K28.5 comma word alignment
//               and lock qualification. Optional build macro
//               DESER_ALIGN_TMR_EN triplicates state, phase and lock_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module deser_align #(
  parameter int LOCK_COMMAS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  output logic [9:0] data_out,
  output logic       data_valid,
  output logic       is_comma,
  output logic       locked,
  output logic       realign
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [9:0] c_K285_NEG = 10'h0FA;
  localparam logic [9:0] c_K285_POS = 10'h305;
  localparam logic [3:0] c_LOCK_CNT = 4'(LOCK_COMMAS);
  localparam state_t     c_ACQ_STATE = (LOCK_COMMAS == 1) ? LOCKED : CHECK;

  logic [9:0] r_sr;
  state_t     w_state;
  state_t     w_state_nxt;
  logic [3:0] w_phase;
  logic [3:0] w_phase_nxt;
  logic [3:0] w_lock_cnt;
  logic [3:0] w_lock_cnt_nxt;
  logic       w_comma;
  logic       w_boundary;
  logic       w_realign_nxt;

  assign w_comma    = (r_sr == c_K285_NEG) || (r_sr == c_K285_POS);
  assign w_boundary = (w_phase == 4'd0);

  always_comb begin
    w_state_nxt    = w_state;
    w_phase_nxt    = (w_phase == 4'd9) ? 4'd0 : w_phase + 4'd1;
    w_lock_cnt_nxt = w_lock_cnt;
    w_realign_nxt  = 1'b0;
    case (w_state)
      HUNT: begin
        if (w_comma) begin
          w_phase_nxt    = 4'd1;
          w_lock_cnt_nxt = 4'd1;
          w_realign_nxt  = 1'b1;
          w_state_nxt    = c_ACQ_STATE;
        end
      end
      CHECK, LOCKED: begin
        // A comma off the current boundary restarts acquisition on the new alignment
        if (w_comma && !w_boundary) begin
          w_phase_nxt    = 4'd1;
          w_lock_cnt_nxt = 4'd1;
          w_realign_nxt  = 1'b1;
          w_state_nxt    = c_ACQ_STATE;
        end else if ((w_state == CHECK) && w_boundary && w_comma) begin
          if (w_lock_cnt >= c_LOCK_CNT - 4'd1) begin
            w_lock_cnt_nxt = c_LOCK_CNT;
            w_state_nxt    = LOCKED;
          end else begin
            w_lock_cnt_nxt = w_lock_cnt + 4'd1;
          end
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

`ifdef DESER_ALIGN_TMR_EN
  logic [1:0] r_state_a, r_state_b, r_state_c;
  logic [3:0] r_phase_a, r_phase_b, r_phase_c;
  logic [3:0] r_lock_cnt_a, r_lock_cnt_b, r_lock_cnt_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_a    <= HUNT;
      r_state_b    <= HUNT;
      r_state_c    <= HUNT;
      r_phase_a    <= 4'd0;
      r_phase_b    <= 4'd0;
      r_phase_c    <= 4'd0;
      r_lock_cnt_a <= 4'd0;
      r_lock_cnt_b <= 4'd0;
      r_lock_cnt_c <= 4'd0;
    end else begin
      r_state_a    <= w_state_nxt;
      r_state_b    <= w_state_nxt;
      r_state_c    <= w_state_nxt;
      r_phase_a    <= w_phase_nxt;
      r_phase_b    <= w_phase_nxt;
      r_phase_c    <= w_phase_nxt;
      r_lock_cnt_a <= w_lock_cnt_nxt;
      r_lock_cnt_b <= w_lock_cnt_nxt;
      r_lock_cnt_c <= w_lock_cnt_nxt;
    end
  end

  assign w_state    = state_t'((r_state_a & r_state_b) | (r_state_b & r_state_c) |
                               (r_state_a & r_state_c));
  assign w_phase    = (r_phase_a & r_phase_b) | (r_phase_b & r_phase_c) |
                      (r_phase_a & r_phase_c);
  assign w_lock_cnt = (r_lock_cnt_a & r_lock_cnt_b) | (r_lock_cnt_b & r_lock_cnt_c) |
                      (r_lock_cnt_a & r_lock_cnt_c);
`else
  state_t     r_state;
  logic [3:0] r_phase;
  logic [3:0] r_lock_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= HUNT;
      r_phase    <= 4'd0;
      r_lock_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  assign w_state    = r_state;
  assign w_phase    = r_phase;
  assign w_lock_cnt = r_lock_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr       <= 10'd0;
      data_out   <= 10'd0;
      data_valid <= 1'b0;
      is_comma   <= 1'b0;
      locked     <= 1'b0;
      realign    <= 1'b0;
    end else begin
      r_sr       <= {r_sr[8:0], in};
      realign    <= w_realign_nxt;
      locked     <= (w_state_nxt == LOCKED);
      data_valid <= 1'b0;
      if ((w_state == LOCKED) && w_boundary) begin
        data_out   <= r_sr;
        is_comma   <= w_comma;
        data_valid <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_deser_align.sv
// ============================================================================
// Module      : tb_deser_align
// Description : Directed self-checking bench for deser_align.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_deser_align;

  logic       clk = 1'b0;
  logic       rst;
  logic       in;
  logic [9:0] data_out;
  logic       data_valid;
  logic       is_comma;
  logic       locked;
  logic       realign;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_valid;
  int cnt_realign;
  int cnt_locked;

  logic       obs_valid   [10];
  logic       obs_realign [10];
  logic       obs_locked  [10];
  logic       obs_comma   [10];
  logic [9:0] obs_data    [10];

  deser_align #(.LOCK_COMMAS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .is_comma   (is_comma),
    .locked     (locked),
    .realign    (realign)
  );

  always #5 clk = ~clk;

  // Drive one bit, let the edge sample it, then look at the outputs 1ns later
  task automatic send_bit(input logic b);
    in = b;
    @(posedge clk);
    #1;
    if (data_valid === 1'b1) cnt_valid++;
    if (realign === 1'b1) cnt_realign++;
    if (locked === 1'b1) cnt_locked++;
  endtask

  task automatic record(input int i);
    obs_valid[i]   = data_valid;
    obs_realign[i] = realign;
    obs_locked[i]  = locked;
    obs_comma[i]   = is_comma;
    obs_data[i]    = data_out;
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++) begin
      send_bit(w[9-i]);
      record(i);
    end
  endtask

  task automatic clear_counts();
    cnt_valid   = 0;
    cnt_realign = 0;
    cnt_locked  = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (data_out !== 10'd0) begin
      n_errors++; $display("FAIL reset_data_out: got %h want 000", data_out);
    end
    n_checks++;
    if ({data_valid, is_comma, locked, realign} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_flags: got v/c/l/r=%b%b%b%b want 0000",
               data_valid, is_comma, locked, realign);
    end
    rst = 1'b0;
  endtask

  task automatic test_lock_acquire();
    clear_counts();
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    send_word(10'h0FA);
    send_word(10'h305);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (obs_realign[i] !== (i == 0)) begin
        n_errors++;
        $display("FAIL acq_realign idx%0d: got %b want %b", i, obs_realign[i], (i == 0));
      end
    end
    send_word(10'h0FA);
    send_word(10'h305);
    n_checks++;
    if (cnt_locked !== 0) begin
      n_errors++; $display("FAIL acq_early_lock: got %0d locked cycles want 0", cnt_locked);
    end
    send_word(10'h0FA);
    n_checks++;
    if (obs_locked[0] !== 1'b1) begin
      n_errors++; $display("FAIL acq_locked: got %b want 1", obs_locked[0]);
    end
    n_checks++;
    if (cnt_valid !== 0 || cnt_realign !== 1) begin
      n_errors++;
      $display("FAIL acq_counts: got valid=%0d realign=%0d want 0/1", cnt_valid, cnt_realign);
    end
    send_word(10'h305);
    n_checks++;
    if ({obs_valid[0], obs_comma[0], obs_data[0]} !== {2'b11, 10'h0FA}) begin
      n_errors++;
      $display("FAIL acq_word1: got v=%b c=%b d=%h want v=1 c=1 d=0FA",
               obs_valid[0], obs_comma[0], obs_data[0]);
    end
    for (int i = 1; i < 10; i++) begin
      n_checks++;
      if (obs_valid[i] !== 1'b0) begin
        n_errors++; $display("FAIL acq_valid_gap idx%0d: got %b want 0", i, obs_valid[i]);
      end
    end
    send_word(10'h0FA);
    n_checks++;
    if ({obs_valid[0], obs_comma[0], obs_data[0]} !== {2'b11, 10'h305}) begin
      n_errors++;
      $display("FAIL acq_word2: got v=%b c=%b d=%h want v=1 c=1 d=305",
               obs_valid[0], obs_comma[0], obs_data[0]);
    end
  endtask

  task automatic test_data_word();
    send_word(10'h2AA);
    send_word(10'h305);
    n_checks++;
    if ({obs_valid[0], obs_comma[0], obs_data[0]} !== {2'b10, 10'h2AA}) begin
      n_errors++;
      $display("FAIL data_word: got v=%b c=%b d=%h want v=1 c=0 d=2AA",
               obs_valid[0], obs_comma[0], obs_data[0]);
    end
    send_word(10'h0FA);
    n_checks++;
    if ({obs_valid[0], obs_comma[0], obs_data[0]} !== {2'b11, 10'h305}) begin
      n_errors++;
      $display("FAIL data_after: got v=%b c=%b d=%h want v=1 c=1 d=305",
               obs_valid[0], obs_comma[0], obs_data[0]);
    end
    n_checks++;
    if (obs_locked[9] !== 1'b1) begin
      n_errors++; $display("FAIL data_locked: got %b want 1", obs_locked[9]);
    end
  endtask

  task automatic test_misalign();
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    send_word(10'h305);
    // Boundary now falls 3 bits early: 000 + first 7 bits of 305
    n_checks++;
    if ({obs_valid[7], obs_comma[7], obs_data[7]} !== {2'b10, 10'h060}) begin
      n_errors++;
      $display("FAIL mis_partial: got v=%b c=%b d=%h want v=1 c=0 d=060",
               obs_valid[7], obs_comma[7], obs_data[7]);
    end
    clear_counts();
    send_word(10'h0FA);
    n_checks++;
    if ({obs_realign[0], obs_locked[0]} !== 2'b10) begin
      n_errors++;
      $display("FAIL mis_realign: got realign=%b locked=%b want 1/0",
               obs_realign[0], obs_locked[0]);
    end
    send_word(10'h305);
    send_word(10'h0FA);
    send_word(10'h305);
    n_checks++;
    if (obs_locked[0] !== 1'b1) begin
      n_errors++; $display("FAIL mis_relock: got %b want 1", obs_locked[0]);
    end
    n_checks++;
    if (cnt_valid !== 0 || cnt_realign !== 1 || cnt_locked !== 10) begin
      n_errors++;
      $display("FAIL mis_counts: got valid=%0d realign=%0d locked=%0d want 0/1/10",
               cnt_valid, cnt_realign, cnt_locked);
    end
    send_word(10'h0FA);
    n_checks++;
    if ({obs_valid[0], obs_data[0]} !== {1'b1, 10'h305}) begin
      n_errors++;
      $display("FAIL mis_word: got v=%b d=%h want v=1 d=305", obs_valid[0], obs_data[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] seq [6];
    seq = '{10'h0FA, 10'h305, 10'h0FA, 10'h305, 10'h0FA, 10'h305};
    for (int i = 0; i < 5; i++) send_bit(i < 2);
    rst = 1'b1;
    in  = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({data_out, data_valid, is_comma, locked, realign} !== 14'd0) begin
      n_errors++;
      $display("FAIL rstmid_outputs: got d=%h v/c/l/r=%b%b%b%b want all 0",
               data_out, data_valid, is_comma, locked, realign);
    end
    rst = 1'b0;
    clear_counts();
    send_bit(1'b0);
    send_bit(1'b0);
    for (int w = 0; w < 6; w++) begin
      send_word(seq[w]);
      if (w == 1) begin
        n_checks++;
        if (obs_realign[0] !== 1'b1) begin
          n_errors++; $display("FAIL rstmid_realign: got %b want 1", obs_realign[0]);
        end
      end
      if (w == 3) begin
        n_checks++;
        if (cnt_locked !== 0) begin
          n_errors++; $display("FAIL rstmid_early_lock: got %0d want 0", cnt_locked);
        end
      end
      if (w == 4) begin
        n_checks++;
        if (obs_locked[0] !== 1'b1) begin
          n_errors++; $display("FAIL rstmid_relock: got %b want 1", obs_locked[0]);
        end
      end
    end
    n_checks++;
    if ({obs_valid[0], obs_data[0]} !== {1'b1, 10'h0FA}) begin
      n_errors++;
      $display("FAIL rstmid_word: got v=%b d=%h want v=1 d=0FA", obs_valid[0], obs_data[0]);
    end
  endtask

  task automatic test_no_comma();
    rst = 1'b1;
    in  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_counts();
    for (int i = 0; i < 500; i++) begin
      send_word(10'h2AA);
      send_word(10'h155);
    end
    n_checks++;
    if (cnt_valid !== 0 || cnt_realign !== 0 || cnt_locked !== 0) begin
      n_errors++;
      $display("FAIL nocomma: got valid=%0d realign=%0d locked=%0d want 0/0/0",
               cnt_valid, cnt_realign, cnt_locked);
    end
  endtask

`ifdef DESER_ALIGN_TMR_EN
  task automatic test_tmr();
    send_word(10'h0FA);
    send_word(10'h305);
    send_word(10'h0FA);
    send_word(10'h305);
    send_word(10'h0FA);
    n_checks++;
    if (obs_locked[0] !== 1'b1) begin
      n_errors++; $display("FAIL tmr_prelock: got %b want 1", obs_locked[0]);
    end
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        force dut.r_phase_b = 4'd7;
        force dut.r_state_c = 2'd0;
      end
      if (i == 4) begin
        release dut.r_phase_b;
        release dut.r_state_c;
      end
      send_bit(i == 0 || i == 1 || i == 7 || i == 9);
      record(i);
    end
    n_checks++;
    if ({obs_valid[0], obs_data[0]} !== {1'b1, 10'h0FA}) begin
      n_errors++;
      $display("FAIL tmr_word: got v=%b d=%h want v=1 d=0FA", obs_valid[0], obs_data[0]);
    end
    send_word(10'h0FA);
    n_checks++;
    if ({obs_valid[0], obs_comma[0], obs_data[0]} !== {2'b11, 10'h305}) begin
      n_errors++;
      $display("FAIL tmr_next: got v=%b c=%b d=%h want v=1 c=1 d=305",
               obs_valid[0], obs_comma[0], obs_data[0]);
    end
    n_checks++;
    if (cnt_valid !== 2 || cnt_realign !== 0 || cnt_locked !== 20) begin
      n_errors++;
      $display("FAIL tmr_counts: got valid=%0d realign=%0d locked=%0d want 2/0/20",
               cnt_valid, cnt_realign, cnt_locked);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    in  = 1'b0;
    clear_counts();
    test_reset();
    test_lock_acquire();
    test_data_word();
    test_misalign();
    test_reset_mid();
    test_no_comma();
`ifdef DESER_ALIGN_TMR_EN
    test_tmr();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
